os_rx_decoder: RTL and testbench
================================

// Module: os_rx_decoder
// PURPOSE
//  Receive-side ordered-set decoder for the USB4 logical layer; the counterpart of the OS encoder in the transmit data bus.
//  Takes the per-lane byte streams lane_0_rx/lane_1_rx from the PHY, frames ordered sets per lane and checks them.
//  Qualifies an OS type only after REP_MIN consecutive error-free repeats, then reports it to the lane-init FSM as a 4-bit code.
// PARAMETERS
//  OS_LEN   8  bytes per ordered set: SYNC + TYPE + (OS_LEN-2) body bytes; legal range 4..16
//  REP_MIN  2  consecutive identical OSes needed before reporting; legal range 1..15
// PORTS
//  fsm_clk      in   1  block clock, rising edge
//  rst          in   1  asynchronous, active-low reset
//  lane_rx_on   in   1  1 = RX lanes enabled; 0 = decoders idle and outputs cleared
//  data_os      in   1  1 = data phase, OS decoding suspended; 0 = OS phase
//  lane_0_rx    in   8  lane 0 received byte, one per clock
//  lane_1_rx    in   8  lane 1 received byte, one per clock
//  os_in_l0     out  4  last qualified OS code, lane 0
//  os_in_l1     out  4  last qualified OS code, lane 1
//  os_valid_l0  out  1  1-cycle pulse on each qualification, lane 0
//  os_valid_l1  out  1  1-cycle pulse on each qualification, lane 1
//  os_err_l0    out  1  1-cycle pulse on a framing/body error, lane 0
//  os_err_l1    out  1  1-cycle pulse on a framing/body error, lane 1
//  lanes_aligned out 1  1 when os_in_l0 == os_in_l1 != OS_NONE
// BEHAVIOUR
//  Reset: all outputs 0; os_in_lx = OS_NONE (4'd0); FSMs in HUNT; counters 0.
//  Codes and TYPE bytes: SLOS1 = 1 / 8'h11; SLOS2 = 2 / 8'h22; TS1 = 3 / 8'h2D; TS2 = 4 / 8'h4A. SYNC byte = 8'hBC.
//  Body byte for each type = ~TYPE byte. Other TYPE values are illegal.
//  Per-lane FSM, one byte per cycle, runs only when lane_rx_on=1 and data_os=0:
//   HUNT: byte==SYNC -> TYPE. Else stay; a non-SYNC byte while rep_cnt>0 clears rep_cnt (no err pulse).
//   TYPE: legal type -> latch cur_type, body_cnt=0 -> BODY. Illegal -> err pulse, rep_cnt=0 -> HUNT.
//   BODY: byte==~cur_type -> body_cnt++. Mismatch -> err pulse, rep_cnt=0 -> HUNT.
//         On accepting body byte OS_LEN-3 the OS is complete -> HUNT.
//  On completion: if cur_type==prev_type then rep_cnt++ (saturate at REP_MIN), else rep_cnt=1; then prev_type=cur_type.
//   Back-to-back OSes with no gap are legal (next SYNC is sampled the cycle after the last body byte).
//  Qualification: on the completion where rep_cnt reaches REP_MIN (new value), registered one cycle later:
//   os_in_lx = code and os_valid_lx = 1 for exactly 1 cycle.
//   Latency: os_valid high the cycle after the last body byte of the REP_MIN-th OS is sampled.
//   Further identical OSes while saturated: no new pulse; os_in holds.
//   A different type qualifying later overwrites os_in and pulses valid again.
//  data_os=1: FSMs forced to HUNT, counters and prev_type cleared; os_in_lx held; valid/err held 0.
//  lane_rx_on=0: same as data_os=1, and os_in_lx cleared to OS_NONE the next clock. This takes priority over data_os.
//  Either gate dropping mid-OS aborts that OS silently (no err pulse). Lanes are fully independent; no cross-lane deskew.
//  Async reset mid-OS: immediate return to reset values; decoding restarts at HUNT after release.
// STRUCTURE
//  Package usb4_os_pkg: OS_NONE/SLOS1/SLOS2/TS1/TS2 code localparams, SYNC and TYPE byte constants,
//   type-byte<->code function, FSM state encoding (HUNT, TYPE, BODY).
//  Sub-module os_lane_decoder (FSM + body_cnt + rep_cnt + output regs), instantiated once per lane.
//  Top level holds only lane gating and the lanes_aligned compare.
// TESTING
//  Reset, then lane_rx_on=1, data_os=0; both lanes send 2x TS1 (BC 2D D2 D2 D2 D2 D2 D2)
//   -> os_in_l0=os_in_l1=3, one valid pulse per lane 1 cycle after byte 16, lanes_aligned=1.
//  Lane 0 sends SLOS1, TS1, SLOS1, SLOS1 -> one valid pulse, after the 4th OS only; os_in_l0=1.
//  Lane 1 sends TS2 with 5th byte 8'h00, then 2x clean TS2 -> err pulse on the bad byte; os_in_l1=4 after the clean pair.
//  Lane 0 sends TYPE byte 8'h55 after SYNC -> os_err_l0 pulse; FSM back in HUNT; os_in_l0 unchanged.
//  Qualify TS2, then set data_os=1 mid-OS -> no err pulse, os_in held at 4;
//   then lane_rx_on=0 -> os_in=0 next clock, lanes_aligned=0.
//  Assert rst low mid-BODY -> outputs 0 immediately; after release, 2 clean SLOS2 -> os_in=2.

Source files
------------

// File: rtl/os_rx_decoder_pkg.sv
// usb4_os_pkg: ordered-set codes, SYNC/TYPE bytes, decoder FSM states and type/code mapping.
package usb4_os_pkg;

    localparam logic [3:0] OS_NONE = 4'd0;
    localparam logic [3:0] SLOS1   = 4'd1;
    localparam logic [3:0] SLOS2   = 4'd2;
    localparam logic [3:0] TS1     = 4'd3;
    localparam logic [3:0] TS2     = 4'd4;

    localparam logic [7:0] SYNC_BYTE  = 8'hBC;
    localparam logic [7:0] SLOS1_BYTE = 8'h11;
    localparam logic [7:0] SLOS2_BYTE = 8'h22;
    localparam logic [7:0] TS1_BYTE   = 8'h2D;
    localparam logic [7:0] TS2_BYTE   = 8'h4A;

    typedef enum logic [1:0] {HUNT, TYPE, BODY} os_state_e;

    function automatic logic [3:0] type_to_code(input logic [7:0] b);
        return b == SLOS1_BYTE ? SLOS1 :
               b == SLOS2_BYTE ? SLOS2 :
               b == TS1_BYTE   ? TS1   :
               b == TS2_BYTE   ? TS2   : OS_NONE;
    endfunction

    function automatic logic [7:0] code_to_type(input logic [3:0] c);
        return c == SLOS1 ? SLOS1_BYTE :
               c == SLOS2 ? SLOS2_BYTE :
               c == TS1   ? TS1_BYTE   :
               c == TS2   ? TS2_BYTE   : 8'h00;
    endfunction

endpackage

// File: rtl/os_rx_decoder_if.sv
// os_rx_decoder_if: lane byte streams, gating controls and per-lane OS reports.
interface os_rx_decoder_if;

    logic       lane_rx_on;
    logic       data_os;
    logic [7:0] lane_0_rx;
    logic [7:0] lane_1_rx;
    logic [3:0] os_in_l0;
    logic [3:0] os_in_l1;
    logic       os_valid_l0;
    logic       os_valid_l1;
    logic       os_err_l0;
    logic       os_err_l1;
    logic       lanes_aligned;

    modport master (
        output lane_rx_on, data_os, lane_0_rx, lane_1_rx,
        input  os_in_l0, os_in_l1, os_valid_l0, os_valid_l1, os_err_l0, os_err_l1, lanes_aligned
    );

    modport slave (
        input  lane_rx_on, data_os, lane_0_rx, lane_1_rx,
        output os_in_l0, os_in_l1, os_valid_l0, os_valid_l1, os_err_l0, os_err_l1, lanes_aligned
    );

endinterface

// File: rtl/os_lane_decoder.sv
// os_lane_decoder: frames and checks ordered sets on one lane, qualifies a type after REP_MIN repeats.
module os_lane_decoder
    import usb4_os_pkg::*;
#(
    parameter int OS_LEN  = 8,
    parameter int REP_MIN = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_on,
    input  logic       data_os,
    input  logic [7:0] rx,
    output logic [3:0] os_in,
    output logic       os_valid,
    output logic       os_err
);

    localparam logic [3:0] LAST = 4'(OS_LEN - 3);
    localparam logic [3:0] REP  = 4'(REP_MIN);

    os_state_e  st;
    logic [3:0] cur_type;
    logic [3:0] prev_type;
    logic [3:0] body_cnt;
    logic [3:0] rep_cnt;
    logic [3:0] rep_nxt;
    logic       same;
    logic       body_ok;
    logic       qualify;

    always_comb begin
        same    = cur_type == prev_type;
        rep_nxt = !same ? 4'd1 : (rep_cnt == REP ? REP : rep_cnt + 4'd1);
        body_ok = rx == ~code_to_type(cur_type);
        // a saturated run of the same type must not re-announce itself
        qualify = rep_nxt == REP && !(same && rep_cnt == REP);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st        <= HUNT;
            cur_type  <= OS_NONE;
            prev_type <= OS_NONE;
            body_cnt  <= '0;
            rep_cnt   <= '0;
            os_in     <= OS_NONE;
            os_valid  <= 1'b0;
            os_err    <= 1'b0;
        end else begin
            os_valid <= 1'b0;
            os_err   <= 1'b0;
            if (!rx_on || data_os) begin
                st        <= HUNT;
                cur_type  <= OS_NONE;
                prev_type <= OS_NONE;
                body_cnt  <= '0;
                rep_cnt   <= '0;
                if (!rx_on) os_in <= OS_NONE;
            end else begin
                case (st)
                    HUNT: begin
                        if (rx == SYNC_BYTE) st <= TYPE;
                        else rep_cnt <= '0;
                    end
                    TYPE: begin
                        if (type_to_code(rx) != OS_NONE) begin
                            cur_type <= type_to_code(rx);
                            body_cnt <= '0;
                            st       <= BODY;
                        end else begin
                            os_err  <= 1'b1;
                            rep_cnt <= '0;
                            st      <= HUNT;
                        end
                    end
                    BODY: begin
                        if (!body_ok) begin
                            os_err  <= 1'b1;
                            rep_cnt <= '0;
                            st      <= HUNT;
                        end else if (body_cnt == LAST) begin
                            st        <= HUNT;
                            rep_cnt   <= rep_nxt;
                            prev_type <= cur_type;
                            if (qualify) begin
                                os_valid <= 1'b1;
                                os_in    <= cur_type;
                            end
                        end else begin
                            body_cnt <= body_cnt + 4'd1;
                        end
                    end
                    default: st <= HUNT;
                endcase
            end
        end
    end

endmodule

// File: rtl/os_rx_decoder.sv
// os_rx_decoder: two independent lane OS decoders plus the cross-lane alignment flag.
module os_rx_decoder
    import usb4_os_pkg::*;
#(
    parameter int OS_LEN  = 8,
    parameter int REP_MIN = 2
) (
    input logic            fsm_clk,
    input logic            rst,
    os_rx_decoder_if.slave bus
);

    os_lane_decoder #(.OS_LEN(OS_LEN), .REP_MIN(REP_MIN)) u_lane0 (
        .clk      (fsm_clk),
        .rst      (rst),
        .rx_on    (bus.lane_rx_on),
        .data_os  (bus.data_os),
        .rx       (bus.lane_0_rx),
        .os_in    (bus.os_in_l0),
        .os_valid (bus.os_valid_l0),
        .os_err   (bus.os_err_l0)
    );

    os_lane_decoder #(.OS_LEN(OS_LEN), .REP_MIN(REP_MIN)) u_lane1 (
        .clk      (fsm_clk),
        .rst      (rst),
        .rx_on    (bus.lane_rx_on),
        .data_os  (bus.data_os),
        .rx       (bus.lane_1_rx),
        .os_in    (bus.os_in_l1),
        .os_valid (bus.os_valid_l1),
        .os_err   (bus.os_err_l1)
    );

    assign bus.lanes_aligned = (bus.os_in_l0 == bus.os_in_l1) && (bus.os_in_l0 != OS_NONE);

endmodule

// File: tb/tb_os_rx_decoder.sv
// tb_os_rx_decoder: directed checks of OS framing, qualification, gating and reset.
module tb_os_rx_decoder;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   v0, v1, e0, e1, vpos0, vpos1;

    os_rx_decoder_if bus();

    os_rx_decoder #(.OS_LEN(8), .REP_MIN(2)) dut (
        .fsm_clk (clk),
        .rst     (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        v0 = 0; v1 = 0; e0 = 0; e1 = 0; vpos0 = -1; vpos1 = -1;
    endtask

    task automatic step(input logic [7:0] b0, input logic [7:0] b1);
        bus.lane_0_rx = b0;
        bus.lane_1_rx = b1;
        @(posedge clk);
        #1;
        if (bus.os_err_l0) e0++;
        if (bus.os_err_l1) e1++;
    endtask

    // one OS per enabled lane; a disabled lane or a bad index sends 8'h00 instead
    task automatic os2(input logic [7:0] t0, input logic [7:0] t1,
                       input logic en0, input logic en1, input int bad0, input int bad1);
        logic [7:0] b0, b1;
        for (int i = 0; i < 8; i++) begin
            b0 = i == 0 ? 8'hBC : i == 1 ? t0 : ~t0;
            b1 = i == 0 ? 8'hBC : i == 1 ? t1 : ~t1;
            if (!en0 || i == bad0) b0 = 8'h00;
            if (!en1 || i == bad1) b1 = 8'h00;
            step(b0, b1);
            if (bus.os_valid_l0) begin v0++; vpos0 = i; end
            if (bus.os_valid_l1) begin v1++; vpos1 = i; end
        end
    endtask

    initial begin
        bus.lane_rx_on = 1'b0;
        bus.data_os    = 1'b0;
        bus.lane_0_rx  = 8'h00;
        bus.lane_1_rx  = 8'h00;
        #12;
        chk("rst_os_in_l0", 32'(bus.os_in_l0), 0);
        chk("rst_valid", 32'({bus.os_valid_l0, bus.os_valid_l1, bus.os_err_l0, bus.os_err_l1}), 0);
        chk("rst_aligned", 32'(bus.lanes_aligned), 0);
        @(posedge clk); #1;
        rst = 1'b1;
        bus.lane_rx_on = 1'b1;

        // 2x TS1 on both lanes
        clr();
        os2(8'h2D, 8'h2D, 1, 1, -1, -1);
        chk("ts1_first_no_valid", 32'(v0 + v1), 0);
        os2(8'h2D, 8'h2D, 1, 1, -1, -1);
        chk("ts1_valid_cnt_l0", 32'(v0), 1);
        chk("ts1_valid_cnt_l1", 32'(v1), 1);
        chk("ts1_valid_pos_l0", 32'(vpos0), 7);
        chk("ts1_valid_pos_l1", 32'(vpos1), 7);
        chk("ts1_os_in_l0", 32'(bus.os_in_l0), 3);
        chk("ts1_os_in_l1", 32'(bus.os_in_l1), 3);
        chk("ts1_aligned", 32'(bus.lanes_aligned), 1);
        step(8'h00, 8'h00);
        chk("ts1_pulse_one_cycle", 32'({bus.os_valid_l0, bus.os_valid_l1}), 0);
        chk("ts1_no_err", 32'(e0 + e1), 0);

        // lane 0: SLOS1, TS1, SLOS1, SLOS1
        clr();
        os2(8'h11, 8'h00, 1, 0, -1, -1);
        os2(8'h2D, 8'h00, 1, 0, -1, -1);
        os2(8'h11, 8'h00, 1, 0, -1, -1);
        chk("mix_no_early_valid", 32'(v0), 0);
        chk("mix_os_in_held", 32'(bus.os_in_l0), 3);
        os2(8'h11, 8'h00, 1, 0, -1, -1);
        chk("mix_valid_cnt", 32'(v0), 1);
        chk("mix_valid_pos", 32'(vpos0), 7);
        chk("mix_os_in_l0", 32'(bus.os_in_l0), 1);
        chk("mix_l1_held", 32'(bus.os_in_l1), 3);
        chk("mix_not_aligned", 32'(bus.lanes_aligned), 0);

        // lane 1: TS2 with corrupted 5th byte, then 2x clean TS2
        clr();
        os2(8'h00, 8'h4A, 0, 1, -1, 4);
        chk("ts2_bad_err_cnt", 32'(e1), 1);
        chk("ts2_bad_os_in", 32'(bus.os_in_l1), 3);
        os2(8'h00, 8'h4A, 0, 1, -1, -1);
        os2(8'h00, 8'h4A, 0, 1, -1, -1);
        chk("ts2_valid_cnt", 32'(v1), 1);
        chk("ts2_os_in_l1", 32'(bus.os_in_l1), 4);
        chk("ts2_total_err", 32'(e1), 1);
        chk("ts2_l0_quiet", 32'(v0 + e0), 0);

        // lane 0: illegal TYPE byte
        clr();
        os2(8'h55, 8'h00, 1, 0, -1, -1);
        chk("bad_type_err", 32'(e0), 1);
        chk("bad_type_os_in", 32'(bus.os_in_l0), 1);

        // qualify TS2 on both lanes, then data_os mid-OS, then lanes off
        clr();
        os2(8'h4A, 8'h4A, 1, 1, -1, -1);
        os2(8'h4A, 8'h4A, 1, 1, -1, -1);
        chk("q_ts2_valid", 32'(v0 * 16 + v1), 32'h11);
        chk("q_ts2_aligned", 32'(bus.lanes_aligned), 1);
        clr();
        step(8'hBC, 8'hBC);
        step(8'h4A, 8'h4A);
        step(8'hB5, 8'hB5);
        bus.data_os = 1'b1;
        step(8'h00, 8'h00);
        step(8'hB5, 8'hB5);
        chk("dos_no_err", 32'(e0 + e1), 0);
        chk("dos_os_in_held", 32'({bus.os_in_l0, bus.os_in_l1}), 32'h44);
        chk("dos_no_valid", 32'({bus.os_valid_l0, bus.os_valid_l1}), 0);
        bus.lane_rx_on = 1'b0;
        step(8'h00, 8'h00);
        chk("off_os_in", 32'({bus.os_in_l0, bus.os_in_l1}), 0);
        chk("off_aligned", 32'(bus.lanes_aligned), 0);

        // async reset mid-BODY, then 2x SLOS2
        bus.data_os = 1'b0;
        bus.lane_rx_on = 1'b1;
        clr();
        os2(8'h2D, 8'h2D, 1, 1, -1, -1);
        os2(8'h2D, 8'h2D, 1, 1, -1, -1);
        chk("pre_rst_os_in", 32'({bus.os_in_l0, bus.os_in_l1}), 32'h33);
        step(8'hBC, 8'hBC);
        step(8'h22, 8'h22);
        step(8'hDD, 8'hDD);
        #2 rst = 1'b0;
        #1;
        chk("arst_os_in", 32'({bus.os_in_l0, bus.os_in_l1}), 0);
        chk("arst_aligned", 32'(bus.lanes_aligned), 0);
        @(posedge clk); #1;
        rst = 1'b1;
        clr();
        os2(8'h22, 8'h22, 1, 1, -1, -1);
        os2(8'h22, 8'h22, 1, 1, -1, -1);
        chk("slos2_valid", 32'(v0 * 16 + v1), 32'h11);
        chk("slos2_os_in", 32'({bus.os_in_l0, bus.os_in_l1}), 32'h22);
        chk("slos2_aligned", 32'(bus.lanes_aligned), 1);
        chk("slos2_no_err", 32'(e0 + e1), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
